// File: rtl/gppcu_instr_dispatcher_pkg.sv
// Shared definitions for the GPPCU instruction dispatcher.
//   DBW_DEFAULT      : default instruction word width
//   dispatch_state_e : dispatcher FSM encoding (Idle=0, Run=1, Drain=2)
package gppcu_instr_dispatcher_pkg;

    localparam int unsigned DBW_DEFAULT = 32;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2
    } dispatch_state_e;

endpackage

// File: rtl/gppcu_skid_fifo.sv
// Two-entry skid FIFO between the instruction RAM read port and the core.
// Ports:
//   clk_i, rst_i   : clock, synchronous active-high reset
//   flush_i        : drop all entries (wins over push/pop)
//   push_i, data_i : write an entry (ignored when full and not popping)
//   pop_i          : consume the head entry
//   data_o/valid_o : head entry and its valid flag
//   count_o        : number of occupied entries (0..2)
module gppcu_skid_fifo #(
    parameter int unsigned Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             valid_o,
    output logic [1:0]       count_o
);

    logic [Width-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic             push_ok;
    logic             pop_ok;

    assign pop_ok  = pop_i && (count_q != 2'd0);
    assign push_ok = push_i && ((count_q != 2'd2) || pop_ok);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (flush_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_ok) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            unique case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign valid_o = (count_q != 2'd0);
    assign count_o = count_q;

endmodule

// File: rtl/gppcu_instr_dispatcher.sv
// GPPCU instruction dispatcher: host-loaded instruction RAM streamed into the
// core's instruction port over a valid/ready handshake.
// Optional feature macro: GPPCU_DISPATCH_REPEAT_EN (adds iREPEAT, issues the
// range iREPEAT+1 times back to back, widens oISSUED by 8 bits).
// Ports:
//   iACLK, iRST                        : clock, synchronous active-high reset
//   iPROG_WR/iPROG_ADDR/iPROG_WDATA    : host RAM write (ignored while busy)
//   iSTART/iSTART_ADDR/iLENGTH         : start a run (sampled in idle only)
//   iABORT                             : cancel the current run
//   oINSTR/oINSTR_VALID/iINSTR_READY   : instruction stream to the core
//   oBUSY, oDONE, oISSUED              : run status, completion pulse, count
module gppcu_instr_dispatcher
    import gppcu_instr_dispatcher_pkg::*;
#(
    parameter int unsigned DBW   = DBW_DEFAULT,
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = $clog2(DEPTH),
    parameter int unsigned LW    = AW + 1,
`ifdef GPPCU_DISPATCH_REPEAT_EN
    parameter int unsigned IW    = LW + 8
`else
    parameter int unsigned IW    = LW
`endif
) (
    input  logic           iACLK,
    input  logic           iRST,
    input  logic           iPROG_WR,
    input  logic [AW-1:0]  iPROG_ADDR,
    input  logic [DBW-1:0] iPROG_WDATA,
    input  logic           iSTART,
    input  logic [AW-1:0]  iSTART_ADDR,
    input  logic [LW-1:0]  iLENGTH,
`ifdef GPPCU_DISPATCH_REPEAT_EN
    input  logic [7:0]     iREPEAT,
`endif
    input  logic           iABORT,
    output logic [DBW-1:0] oINSTR,
    output logic           oINSTR_VALID,
    input  logic           iINSTR_READY,
    output logic           oBUSY,
    output logic           oDONE,
    output logic [IW-1:0]  oISSUED
);

    dispatch_state_e state_q, state_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   rem_q, rem_d;
    logic [IW-1:0]   issued_q, issued_d;
    logic [IW-1:0]   total_q, total_d;
    logic            done_q, done_d;
    logic            rd_vld_q;
    logic [DBW-1:0]  ram_rdata_q;
    logic [DBW-1:0]  mem [DEPTH];
`ifdef GPPCU_DISPATCH_REPEAT_EN
    logic [7:0]      pass_q, pass_d;
    logic [AW-1:0]   base_q, base_d;
    logic [LW-1:0]   len_q, len_d;
`endif

    logic [1:0]      fifo_count;
    logic            fifo_valid;
    logic [DBW-1:0]  fifo_data;
    logic [1:0]      occ;
    logic            xfer;
    logic            rd_en;
    logic            abort;

    assign xfer  = fifo_valid && iINSTR_READY;
    assign abort = iABORT && (state_q != StIdle);
    // Entries held plus the read still in the RAM pipeline must fit in two slots.
    assign occ   = fifo_count + {1'b0, rd_vld_q};
    assign rd_en = (state_q == StRun) && (rem_q != '0) && ((occ < 2'd2) || xfer);

    always_ff @(posedge iACLK) begin
        if (iPROG_WR && (state_q == StIdle)) begin
            mem[iPROG_ADDR] <= iPROG_WDATA;
        end
        if (rd_en) begin
            ram_rdata_q <= mem[rd_ptr_q];
        end
    end

    gppcu_skid_fifo #(
        .Width (DBW)
    ) u_skid_fifo (
        .clk_i   (iACLK),
        .rst_i   (iRST),
        .flush_i (abort),
        .push_i  (rd_vld_q),
        .data_i  (ram_rdata_q),
        .pop_i   (xfer),
        .data_o  (fifo_data),
        .valid_o (fifo_valid),
        .count_o (fifo_count)
    );

    always_comb begin
        state_d  = state_q;
        rd_ptr_d = rd_ptr_q;
        rem_d    = rem_q;
        issued_d = issued_q;
        total_d  = total_q;
        done_d   = 1'b0;
`ifdef GPPCU_DISPATCH_REPEAT_EN
        pass_d   = pass_q;
        base_d   = base_q;
        len_d    = len_q;
`endif
        if (xfer && (issued_q != total_q)) begin
            issued_d = issued_q + IW'(1);
        end
        unique case (state_q)
            StIdle: begin
                if (iSTART) begin
                    rd_ptr_d = iSTART_ADDR;
                    rem_d    = iLENGTH;
                    issued_d = '0;
`ifdef GPPCU_DISPATCH_REPEAT_EN
                    pass_d   = iREPEAT;
                    base_d   = iSTART_ADDR;
                    len_d    = iLENGTH;
                    total_d  = IW'(iLENGTH) * (IW'(iREPEAT) + IW'(1));
`else
                    total_d  = IW'(iLENGTH);
`endif
                    if (iLENGTH == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                if (rd_en) begin
                    rd_ptr_d = rd_ptr_q + AW'(1);
                    rem_d    = rem_q - LW'(1);
                    if (rem_q == LW'(1)) begin
`ifdef GPPCU_DISPATCH_REPEAT_EN
                        // Reload the range for the next pass without a bubble.
                        if (pass_q != 8'd0) begin
                            rd_ptr_d = base_q;
                            rem_d    = len_q;
                            pass_d   = pass_q - 8'd1;
                        end else begin
                            state_d = StDrain;
                        end
`else
                        state_d = StDrain;
`endif
                    end
                end
            end
            StDrain: begin
                // All reads issued: the last word leaves when the FIFO holds one
                // entry, nothing is in flight, and the core takes it.
                if (xfer && (fifo_count == 2'd1) && !rd_vld_q) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        if (abort) begin
            state_d = StIdle;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge iACLK) begin
        if (iRST) begin
            state_q  <= StIdle;
            rd_ptr_q <= '0;
            rem_q    <= '0;
            issued_q <= '0;
            total_q  <= '0;
            done_q   <= 1'b0;
            rd_vld_q <= 1'b0;
`ifdef GPPCU_DISPATCH_REPEAT_EN
            pass_q   <= '0;
            base_q   <= '0;
            len_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            rem_q    <= rem_d;
            issued_q <= issued_d;
            total_q  <= total_d;
            done_q   <= done_d;
            rd_vld_q <= rd_en && !abort;
`ifdef GPPCU_DISPATCH_REPEAT_EN
            pass_q   <= pass_d;
            base_q   <= base_d;
            len_q    <= len_d;
`endif
        end
    end

    assign oINSTR       = fifo_data;
    assign oINSTR_VALID = fifo_valid;
    assign oBUSY        = (state_q != StIdle);
    assign oDONE        = done_q;
    assign oISSUED      = issued_q;

endmodule

// File: tb/tb_gppcu_instr_dispatcher.sv
// Self-checking bench for gppcu_instr_dispatcher: a shadow program memory
// produces the expected instruction stream, a monitor pops and compares it.
module tb_gppcu_instr_dispatcher;

    localparam int DEPTH = 256;

    logic        clk;
    logic        iRST;
    logic        iPROG_WR;
    logic [7:0]  iPROG_ADDR;
    logic [31:0] iPROG_WDATA;
    logic        iSTART;
    logic [7:0]  iSTART_ADDR;
    logic [8:0]  iLENGTH;
    logic        iABORT;
    logic [31:0] oINSTR;
    logic        oINSTR_VALID;
    logic        iINSTR_READY;
    logic        oBUSY;
    logic        oDONE;
`ifdef GPPCU_DISPATCH_REPEAT_EN
    logic [16:0] oISSUED;
    logic [7:0]  iREPEAT;
`else
    logic [8:0]  oISSUED;
`endif

    logic [31:0] mem_model [DEPTH];
    logic [31:0] sb [$];
    int          checks;
    int          errors;
    int          rmode;
    logic        rdy_manual;

    gppcu_instr_dispatcher u_dut (
        .iACLK        (clk),
        .iRST         (iRST),
        .iPROG_WR     (iPROG_WR),
        .iPROG_ADDR   (iPROG_ADDR),
        .iPROG_WDATA  (iPROG_WDATA),
        .iSTART       (iSTART),
        .iSTART_ADDR  (iSTART_ADDR),
        .iLENGTH      (iLENGTH),
`ifdef GPPCU_DISPATCH_REPEAT_EN
        .iREPEAT      (iREPEAT),
`endif
        .iABORT       (iABORT),
        .oINSTR       (oINSTR),
        .oINSTR_VALID (oINSTR_VALID),
        .iINSTR_READY (iINSTR_READY),
        .oBUSY        (oBUSY),
        .oDONE        (oDONE),
        .oISSUED      (oISSUED)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Ready generator: 0 = held high, 1 = pattern 1,0,0,1, 2 = random, 3 = manual.
    initial begin
        int ph;
        ph = 0;
        iINSTR_READY = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0: iINSTR_READY = 1'b1;
                1: begin
                    iINSTR_READY = (ph == 0) || (ph == 3);
                    ph = (ph + 1) % 4;
                end
                2: iINSTR_READY = ($urandom_range(0, 1) == 1);
                default: iINSTR_READY = rdy_manual;
            endcase
        end
    end

    // Monitor: pops the scoreboard on each transfer, checks stall stability.
    initial begin
        logic        stalled;
        logic        prev_cut;
        logic [31:0] held;
        logic [31:0] exp;
        stalled  = 1'b0;
        prev_cut = 1'b0;
        held     = '0;
        forever begin
            @(negedge clk);
            if (stalled && !prev_cut) begin
                chk("stall_valid", oINSTR_VALID, 1);
                chk("stall_hold", oINSTR, held);
            end
            if (oINSTR_VALID && iINSTR_READY) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_xfer actual=%0h required=none", oINSTR);
                end else begin
                    exp = sb.pop_front();
                    chk("instr", oINSTR, exp);
                end
            end
            stalled  = oINSTR_VALID && !iINSTR_READY;
            held     = oINSTR;
            prev_cut = iABORT || iRST;
        end
    end

    task automatic set_mode(input int m, input logic v);
        @(negedge clk);
        rmode      = m;
        rdy_manual = v;
    endtask

    task automatic prog_write(input int a, input logic [31:0] d, input bit update);
        @(posedge clk);
        #1;
        iPROG_WR    = 1'b1;
        iPROG_ADDR  = a[7:0];
        iPROG_WDATA = d;
        if (update) mem_model[a] = d;
        @(posedge clk);
        #1;
        iPROG_WR = 1'b0;
    endtask

    task automatic start_pulse(input int sa, input int len);
        for (int i = 0; i < len; i++) sb.push_back(mem_model[(sa + i) % DEPTH]);
        @(posedge clk);
        #1;
        iSTART_ADDR = sa[7:0];
        iLENGTH     = len[8:0];
        iSTART      = 1'b1;
        @(posedge clk);
        #1;
        iSTART = 1'b0;
    endtask

    // exp_done < 0 means the completion cycle depends on ready and is not checked.
    task automatic run(input int sa, input int len, input int exp_done);
        int done_k;
        int first_k;
        start_pulse(sa, len);
        done_k  = -1;
        first_k = -1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (k == 0) chk("busy_after_start", oBUSY, (len != 0));
            if (first_k < 0 && oINSTR_VALID) first_k = k;
            if (oDONE) begin
                done_k = k;
                break;
            end
        end
        if (done_k < 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual=none required=done");
        end else if (exp_done >= 0) begin
            chk("done_cycle", done_k, exp_done);
        end
        if (len > 0) chk("first_valid_cycle", first_k, 2);
        else chk("len0_no_valid", first_k, -1);
        chk("busy_at_done", oBUSY, 0);
        chk("issued_at_done", oISSUED, len);
        chk("sb_empty_at_done", sb.size(), 0);
        @(negedge clk);
        chk("done_single_pulse", oDONE, 0);
        chk("valid_after_done", oINSTR_VALID, 0);
    endtask

    initial begin
        int n;
        checks      = 0;
        errors      = 0;
        rmode       = 0;
        rdy_manual  = 1'b1;
        iRST        = 1'b1;
        iPROG_WR    = 1'b0;
        iPROG_ADDR  = '0;
        iPROG_WDATA = '0;
        iSTART      = 1'b0;
        iSTART_ADDR = '0;
        iLENGTH     = '0;
        iABORT      = 1'b0;
`ifdef GPPCU_DISPATCH_REPEAT_EN
        iREPEAT     = '0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", oINSTR_VALID, 0);
        chk("rst_busy", oBUSY, 0);
        chk("rst_done", oDONE, 0);
        chk("rst_issued", oISSUED, 0);
        chk("rst_instr", oINSTR, 0);
        @(posedge clk);
        #1;
        iRST = 1'b0;

        for (int i = 0; i < DEPTH; i++) prog_write(i, $urandom, 1'b1);
        for (int i = 0; i < 8; i++) prog_write(i, 32'h100 + i, 1'b1);

        // Basic run with ready high, then with the 1,0,0,1 ready pattern.
        run(0, 8, 10);
        set_mode(1, 1'b1);
        run(0, 8, -1);
        set_mode(0, 1'b1);

        // Wrap from the top of the RAM, then a zero-length run.
        run(254, 4, 6);
        run(17, 0, 0);
        repeat (3) begin
            @(negedge clk);
            chk("len0_valid_idle", oINSTR_VALID, 0);
        end

        // Abort after three transfers with ready low.
        set_mode(3, 1'b1);
        start_pulse(40, 8);
        n = 0;
        for (int k = 0; k < 50 && n < 3; k++) begin
            @(negedge clk);
            if (oINSTR_VALID && iINSTR_READY) n++;
            if (n == 3) rdy_manual = 1'b0;
        end
        chk("abort_reached_3", n, 3);
        @(posedge clk);
        #1;
        iABORT = 1'b1;
        @(posedge clk);
        #1;
        iABORT = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("abort_valid_drop", oINSTR_VALID, 0);
        chk("abort_busy", oBUSY, 0);
        chk("abort_issued", oISSUED, 3);
        repeat (4) begin
            @(negedge clk);
            chk("abort_no_done", oDONE, 0);
        end
        set_mode(0, 1'b1);
        run($urandom_range(0, 255), 5, 7);

        // Reset mid-run with a host write attempted while busy.
        start_pulse(16, 8);
        repeat (3) @(posedge clk);
        prog_write(80, 32'hDEAD_BEEF, 1'b0);
        @(posedge clk);
        #1;
        iRST = 1'b1;
        @(posedge clk);
        #1;
        iRST = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("midrst_valid", oINSTR_VALID, 0);
        chk("midrst_busy", oBUSY, 0);
        chk("midrst_done", oDONE, 0);
        chk("midrst_issued", oISSUED, 0);
        chk("midrst_instr", oINSTR, 0);
        run(79, 3, 5);

        // Randomised runs across ready modes.
        for (int r = 0; r < 8; r++) begin
            int m;
            int len;
            m   = $urandom_range(0, 2);
            len = $urandom_range(1, 12);
            set_mode(m, 1'b1);
            run($urandom_range(0, 255), len, (m == 0) ? len + 2 : -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gppcu_instr_dispatcher.md
# gppcu_instr_dispatcher

Instruction-issuing master for a GPPCU core. Holds a host-loaded program in an internal instruction RAM and, on start, streams a contiguous range of instruction words into the core's instruction port over a valid/ready handshake. It is the initiator for the core's `iINSTR`/`iINSTR_VALID`/`oINSTR_READY` port and sits between the host control bus and the core.

## Interface
- `DBW`, 32, instruction word width
- `DEPTH`, 256, instruction RAM words (power of two)
- `AW`, $clog2(DEPTH), RAM address width
- `LW`, AW+1, length field width (0..DEPTH)

Ports:
- `iACLK` in 1: clock; all logic is on its rising edge.
- `iRST` in 1: reset, synchronous, active-high.
- `iPROG_WR` in 1: host write strobe into the instruction RAM.
- `iPROG_ADDR` in AW: host write address.
- `iPROG_WDATA` in DBW: host write data.
- `iSTART` in 1: start pulse, sampled only in IDLE.
- `iSTART_ADDR` in AW: first instruction address.
- `iLENGTH` in LW: number of instructions to issue.
- `iABORT` in 1: cancel the current run.
- `oINSTR` out DBW: instruction to the core.
- `oINSTR_VALID` out 1: `oINSTR` is valid.
- `iINSTR_READY` in 1: the core accepts this cycle.
- `oBUSY` out 1: a run is in progress.
- `oDONE` out 1: one-cycle pulse when a run completes normally.
- `oISSUED` out LW: count of instructions accepted in the current or last run.

## Operation
- A transfer occurs in any cycle where `oINSTR_VALID & iINSTR_READY`.
- Instruction RAM: 1 write port (host) and 1 read port with synchronous 1-cycle read.
- `iPROG_WR` is ignored while `oBUSY=1`.
- FSM states:
  - IDLE: on `iSTART` latch the start address into `rd_ptr` and the length into `rem`, clear `oISSUED`, go to RUN. If `iLENGTH=0`, go to IDLE and pulse `oDONE` next cycle.
  - RUN: issue a RAM read whenever `rem_reads>0` and the output buffer has a free slot (counting reads in flight). `rd_ptr` increments modulo DEPTH, so runs wrap from DEPTH-1 to 0. When all reads have been issued, go to DRAIN.
  - DRAIN: wait until the last transfer occurs, then pulse `oDONE` and go to IDLE.
- Output buffer: 2-entry FIFO (skid) fed by RAM read data. It gives full throughput with a 1-cycle RAM latency and lets `iINSTR_READY` drop without losing data.
- `oINSTR` and `oINSTR_VALID` are driven from the FIFO head. While valid and not ready, `oINSTR` holds stable.
- `oISSUED` increments on each transfer and saturates at `iLENGTH`.
- `iABORT` is accepted in RUN or DRAIN and ignored in IDLE. On abort:
  - flush the FIFO and discard in-flight reads;
  - `oINSTR_VALID=0` from the next cycle;
  - go to IDLE with no `oDONE`;
  - `oISSUED` keeps its value.
- Simultaneous abort and transfer in the same cycle: the transfer counts, then the abort applies.
- `iSTART` outside IDLE is ignored.
- Reset mid-run behaves like abort, plus the following reset values: `oINSTR_VALID=0`, `oBUSY=0`, `oDONE=0`, `oISSUED=0`, `oINSTR=0`, state IDLE. RAM contents are not cleared.

## Timing
- `iSTART` at edge T: `oBUSY=1` after T. The first RAM read happens at T+1. The earliest `oINSTR_VALID=1` is after T+2.
- With `iINSTR_READY` held high, throughput is 1 instruction per cycle. A run of N≥1 takes N+2 cycles from start to the last transfer. `oDONE` is high in the cycle after the last transfer, and `oBUSY` falls in that same cycle.
- Ready deassert or reassert costs no bubble. The FIFO never overflows: a read is issued only if `fifo_count + inflight < 2`, or if the FIFO is being popped this cycle.
- `oINSTR_VALID` never depends combinationally on `iINSTR_READY`.

## Configuration
- `GPPCU_DISPATCH_REPEAT_EN`:
  - Defined: adds input `iREPEAT` [7:0], latched at start. The range is issued `iREPEAT+1` times back to back with no bubble between passes. `rd_ptr` reloads the start address after each pass. `oISSUED` widens to LW+8 and counts all passes. `oDONE` fires after the final pass.
  - Not defined: the port is absent and the range is issued once.

## Structure
- Shared parameter header holds:
  - FSM state encodings (IDLE=0, RUN=1, DRAIN=2);
  - the `DBW` default.
- Sub-module `gppcu_skid_fifo`: 2-entry, width `DBW`, push/pop/flush, with count output.
- The RAM is inferred inline.

## Test plan
- Load addresses 0..7 with 0x100+i, start at addr 0 with length 8, ready held high → 0x100..0x107 in order on 8 consecutive cycles beginning at T+2; `oDONE` pulses once; `oISSUED=8`.
- Same program, ready toggling 1,0,0,1 repeatedly → same 8 words, none duplicated or lost; `oINSTR` stable in every stalled cycle.
- DEPTH=256, start at addr 254 with length 4 → words from addresses 254, 255, 0, 1.
- Length 0 → `oINSTR_VALID` never rises; `oDONE` pulses at T+1.
- Abort after 3 transfers while ready is low → valid drops the next cycle; no `oDONE`; `oISSUED=3`. A new start then works normally.
- `iRST` mid-run and host write while busy → outputs return to reset values; the write during busy leaves the RAM unchanged.
